// File: rtl/fc_pkg.sv
// Shared definitions for the FC partial-sum drain block.
//   ACC_W / DATA_W      : accumulator and activation widths
//   fc_state_e          : drain controller states
//   SAT_MAX / SAT_MIN   : int8 saturation limits
//   requant()           : shift, optional ReLU, int8 saturation
package fc_pkg;

  localparam int ACC_W  = 32;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fc_state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

  // Arithmetic shift truncates toward minus infinity; ReLU is applied
  // before saturation so a clamped value can never wrap.
  function automatic logic signed [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0] value,
    input logic        [4:0]       shift,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] r;
    r = value >>> shift;
    if (relu && (r < 0)) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_out_fifo.sv
// Synchronous output FIFO for requantized activations.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   push_i        : write push_data_i (ignored when full unless popping)
//   push_data_i   : int8 word to store
//   pop_i         : remove the head word (ignored when empty)
//   head_o        : word at the head of the FIFO
//   count_o       : number of words held
//   full_o/empty_o: occupancy flags
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module fc_out_fifo
  import fc_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en;
  logic              rd_en;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the head leaves in the
  // same cycle: the freed slot is the one being written.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fc_psum_drain.sv
// Drains partial sums from the bottom PE of an FC column, accumulates the
// tiles of each output neuron, adds bias, requantizes to int8 and buffers
// the activations for the downstream consumer.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   cfg_start            : job start pulse, sampled in IDLE only
//   cfg_num_tiles        : beats per neuron (0 treated as 1)
//   cfg_num_outputs      : neurons per job
//   cfg_shift, cfg_relu  : requantization controls
//   psum_i, psum_valid_i : partial-sum beat from the PE column
//   bias_i               : bias, taken with the final tile beat
//   out_ready_i          : downstream accepts out_data_o
//   out_valid_o/out_data_o : FIFO head
//   stall_o              : upstream must stop sending beats
//   busy_o, done_o       : job status
//   err_ovf_o            : sticky, a word was dropped on a full FIFO
//
// state | meaning
// IDLE  | waiting for cfg_start, beats ignored
// RUN   | accepting beats, accumulating neurons
// FLUSH | all beats in, waiting for post stage and FIFO to drain
module fc_psum_drain
  import fc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic [7:0]               cfg_num_tiles,
  input  logic [15:0]              cfg_num_outputs,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic signed [ACC_W-1:0]  psum_i,
  input  logic                     psum_valid_i,
  input  logic signed [ACC_W-1:0]  bias_i,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     stall_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_ovf_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] STALL_LVL = (CNT_W + 1)'(FIFO_DEPTH - 1);

  fc_state_e               state_q;
  logic                    busy_q;
  logic [7:0]              tiles_last_q;
  logic [15:0]             outputs_last_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [7:0]              tile_cnt_q;
  logic [15:0]             neuron_cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] post_q;
  logic                    post_valid_q;
  logic                    err_ovf_q;

  logic                    beat_acc;
  logic                    tile_last;
  logic                    neuron_last;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] post_d;
  logic [DATA_W-1:0]       word_d;

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_W-1:0]       fifo_head;
  logic [CNT_W:0]          occupancy;

  assign beat_acc    = (state_q == RUN) && psum_valid_i;
  assign tile_last   = (tile_cnt_q == tiles_last_q);
  assign neuron_last = (neuron_cnt_q == outputs_last_q);

  // Tile 0 restarts the sum, so the stale accumulator is masked instead
  // of being cleared between neurons.
  always_comb begin
    acc_d  = psum_i;
    post_d = '0;
    if (tile_cnt_q != '0) begin
      acc_d = acc_q + psum_i;
    end
    post_d = acc_d + bias_i;
  end

  assign word_d = requant(post_q, shift_q, relu_q);

  fc_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (post_valid_q),
    .push_data_i (word_d),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_head;
  assign fifo_pop    = out_valid_o && out_ready_i;

  // The word in the post stage is already committed, so it counts toward
  // the fill level; the one spare slot absorbs the beat in flight.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, post_valid_q};
  assign stall_o   = (occupancy >= STALL_LVL);

  assign busy_o    = busy_q;
  assign err_ovf_o = err_ovf_q;
  assign done_o    = (state_q == FLUSH) && !post_valid_q && fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      tiles_last_q   <= '0;
      outputs_last_q <= '0;
      shift_q        <= '0;
      relu_q         <= 1'b0;
      tile_cnt_q     <= '0;
      neuron_cnt_q   <= '0;
      acc_q          <= '0;
      post_q         <= '0;
      post_valid_q   <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            tiles_last_q   <= (cfg_num_tiles == 8'd0) ? 8'd0 : cfg_num_tiles - 8'd1;
            outputs_last_q <= cfg_num_outputs - 16'd1;
            shift_q        <= cfg_shift;
            relu_q         <= cfg_relu;
            tile_cnt_q     <= '0;
            neuron_cnt_q   <= '0;
            err_ovf_q      <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= (cfg_num_outputs == 16'd0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (beat_acc) begin
            acc_q <= acc_d;
            if (tile_last) begin
              tile_cnt_q <= '0;
              if (neuron_last) begin
                neuron_cnt_q <= '0;
                state_q      <= FLUSH;
              end else begin
                neuron_cnt_q <= neuron_cnt_q + 16'd1;
              end
            end else begin
              tile_cnt_q <= tile_cnt_q + 8'd1;
            end
          end
        end
        FLUSH: begin
          if (!post_valid_q && fifo_empty) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      post_valid_q <= beat_acc && tile_last;
      if (beat_acc && tile_last) begin
        post_q <= post_d;
      end

      // A post word that finds the FIFO full with no pop is lost.
      if (post_valid_q && fifo_full && !fifo_pop) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fc_psum_drain.md
FC_PSUM_DRAIN -- requirements
Module: fc_psum_drain

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, depth of the output FIFO (power of two, 2 to 16).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cfg_start  in  1  single-cycle job start; sampled only in IDLE.
REQ-005 cfg_num_tiles  in  8  partial-sum beats per output neuron; 0 is treated as 1.
REQ-006 cfg_num_outputs  in  16  neurons per job.
REQ-007 cfg_shift  in  5  arithmetic right-shift for requantization.
REQ-008 cfg_relu  in  1  1 clamps negative results to 0.
REQ-009 psum_i  in  32  signed partial sum from the bottom PE of the FC column.
REQ-010 psum_valid_i  in  1  psum_i is valid this cycle.
REQ-011 bias_i  in  32  signed bias; sampled with the final tile beat of each neuron.
REQ-012 out_ready_i  in  1  downstream accepts out_data_o.
REQ-013 out_valid_o  out  1  FIFO head is valid.
REQ-014 out_data_o  out  8  signed int8 activation at the FIFO head.
REQ-015 stall_o  out  1  upstream must hold psum_valid_i low.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 done_o  out  1  one-cycle pulse on job completion.
REQ-018 err_ovf_o  out  1  sticky flag; set when a beat is dropped because the FIFO is full.

Function
REQ-019 FSM states and transitions:
- IDLE -> RUN on cfg_start; cfg_* values are latched at that edge.
- RUN -> FLUSH when the final beat of the last neuron is accepted.
- FLUSH -> IDLE once the post stage is empty and the FIFO is empty; done_o pulses in that same cycle.
REQ-020 cfg_start in IDLE with cfg_num_outputs=0 moves straight to FLUSH; done_o pulses on the following cycle.
REQ-021 Beats: psum_valid_i is accepted only in RUN; in IDLE and FLUSH it is ignored.
REQ-022 Counters: tile counter 0..num_tiles-1 and neuron counter 0..num_outputs-1, each advanced per accepted beat and wrapping.
REQ-023 Accumulation: the accumulator is loaded with psum_i on tile 0 and adds psum_i on later tiles; arithmetic is 32-bit two's complement, wrapping modulo 2^32.
REQ-024 Final tile, at edge t: post-stage register <= acc + psum_i + bias_i (32-bit wrap), and the post-valid flag is set.
REQ-025 Requantization at edge t+1, written into the FIFO:
- r = post >>> cfg_shift (arithmetic shift, truncation);
- if cfg_relu=1 and r<0, r=0;
- saturate r to [-128,127].
REQ-026 Latency: out_valid_o rises the cycle after edge t+1 when the FIFO was empty, i.e. 2 cycles from the final beat.
REQ-027 Output handshake: a word transfers on out_valid_o && out_ready_i; out_data_o is stable while out_valid_o=1 and out_ready_i=0.
REQ-028 stall_o = (fifo_count + post_valid) >= FIFO_DEPTH-1; this is combinational from registers only.
REQ-029 A simultaneous FIFO push and pop leaves the count unchanged; a push to an empty FIFO with out_ready_i=1 is presented next cycle, with no bypass.
REQ-030 Overflow: if a post-stage word meets a full FIFO with no pop, the word is discarded, err_ovf_o is set, and the counters still advance.
REQ-031 err_ovf_o clears only on reset or on cfg_start.

Reset
REQ-032 While rst_n=0 on an edge:
- FSM -> IDLE;
- counters, accumulator, post-valid flag, FIFO pointers and count are cleared to 0;
- out_valid_o, stall_o, busy_o, done_o and err_ovf_o are all 0.
REQ-033 Reset mid-job abandons the job and drops all words in flight; the next cfg_start begins a fresh job.

Structure
REQ-034 Shared package fc_pkg holds:
- ACC_W=32 and DATA_W=8;
- the FSM state enum (IDLE, RUN, FLUSH);
- the int8 saturation limits.
REQ-035 A single sub-module fc_out_fifo (synchronous FIFO, parameter FIFO_DEPTH, with count output) holds the output buffering; all other logic sits in fc_psum_drain.

Verification
REQ-036 Basic job:
- stimulus: tiles=2, outputs=1, shift=2, relu=0, beats 100 then 200, bias 20, out_ready=1;
- response: one word 80, out_valid_o 2 cycles after the second beat, then done_o.
REQ-037 Saturation:
- stimulus: tiles=1, shift=0, psum 1000, bias 0;
- response: 127. psum -1000 gives -128 with relu=0 and 0 with relu=1.
REQ-038 Backpressure:
- stimulus: outputs=6, tiles=1, out_ready=0;
- response: stall_o high once 3 words are held (FIFO_DEPTH=4) and no data is lost; releasing out_ready drains all 6 in order.
REQ-039 Overflow:
- stimulus: as REQ-038, but keep driving beats despite stall_o;
- response: err_ovf_o=1, exactly 4 words are retained, and err_ovf_o clears on the next cfg_start.
REQ-040 Reset mid-job:
- stimulus: assert rst_n=0 after 3 of 8 outputs;
- response: all outputs 0 next cycle and an empty FIFO; a new job of outputs=1 then completes correctly.
REQ-041 Degenerate configurations:
- cfg_num_outputs=0 -> done_o with no data;
- cfg_num_tiles=0 behaves identically to cfg_num_tiles=1.
